// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: byte FIFO feeding a framer that sends
// preamble 0,0 / sync 1 / d0..d7 LSB first, with an idle-high gap between frames.
module serial_frame_tx #(
    parameter int DEPTH = 4,
    parameter int GAP   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   txd,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        SYNC = 3'd2,
        DATA = 3'd3,
        GAPS = 3'd4
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_reg;
    logic [AW-1:0] rptr_reg;
    logic [CW-1:0] count_reg;

    state_t        state_reg;
    state_t        state_next;
    logic [2:0]    bit_cnt_reg;
    logic [2:0]    bit_cnt_next;
    logic [3:0]    gap_cnt_reg;
    logic [3:0]    gap_cnt_next;
    logic [7:0]    shift_reg;
    logic [7:0]    shift_next;
    logic          txd_reg;
    logic          txd_next;

    logic          push;
    logic          pop;
    logic          fifo_nonempty;

    assign in_ready      = (count_reg != CW'(DEPTH));
    assign push          = in_valid && in_ready;
    assign fifo_nonempty = (count_reg != '0);
    assign fifo_count    = count_reg;
    assign txd           = txd_reg;

    // Storage has no reset so it can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_reg  <= '0;
            rptr_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                wptr_reg <= wptr_reg + AW'(1);
            end
            if (pop) begin
                rptr_reg <= rptr_reg + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // State register and framer datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
            shift_reg   <= '0;
            txd_reg     <= 1'b1;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
            shift_reg   <= shift_next;
            txd_reg     <= txd_next;
        end
    end

    // Next-state logic; the FIFO head is loaded on every transition into PRE.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop          = 1'b1;
                    state_next   = PRE;
                    bit_cnt_next = '0;
                    shift_next   = mem[rptr_reg];
                end
            end
            PRE: begin
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd1) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                state_next   = DATA;
                bit_cnt_next = '0;
            end
            DATA: begin
                if (bit_cnt_reg != 3'd7) begin
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    shift_next   = {1'b0, shift_reg[7:1]};
                end else if (GAP > 0) begin
                    state_next   = GAPS;
                    gap_cnt_next = '0;
                end else if (fifo_nonempty) begin
                    pop          = 1'b1;
                    state_next   = PRE;
                    bit_cnt_next = '0;
                    shift_next   = mem[rptr_reg];
                end else begin
                    state_next = IDLE;
                end
            end
            GAPS: begin
                if (gap_cnt_reg == 4'(GAP - 1)) begin
                    if (fifo_nonempty) begin
                        pop          = 1'b1;
                        state_next   = PRE;
                        bit_cnt_next = '0;
                        shift_next   = mem[rptr_reg];
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // txd is registered from the upcoming state so it lines up with that state.
    always_comb begin
        txd_next = 1'b1;
        busy     = (state_reg != IDLE);
        case (state_next)
            PRE:     txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            default: txd_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed and random checks of serial_frame_tx across four DEPTH/GAP
// configurations, with a bench-side frame decoder standing in for the receiver.
module tb_serial_frame_tx;

    localparam int N_DUT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data  [N_DUT];
    logic       in_valid [N_DUT];
    logic       in_ready [N_DUT];
    logic       txd      [N_DUT];
    logic       busy     [N_DUT];
    logic [3:0] fc       [N_DUT];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instances: 0 = D4/G1, 1 = D4/G0, 2 = D2/G3, 3 = D8/G2
    generate
        for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
            localparam int D = (gi == 2) ? 2 : (gi == 3) ? 8 : 4;
            localparam int G = (gi == 0) ? 1 : (gi == 1) ? 0 : (gi == 2) ? 3 : 2;
            logic [$clog2(D):0] fc_w;
            logic rdy_w;
            logic txd_w;
            logic busy_w;
            serial_frame_tx #(.DEPTH(D), .GAP(G)) u_dut (
                .clk        (clk),
                .rst        (rst),
                .in_data    (in_data[gi]),
                .in_valid   (in_valid[gi]),
                .in_ready   (rdy_w),
                .txd        (txd_w),
                .busy       (busy_w),
                .fifo_count (fc_w)
            );
            assign in_ready[gi] = rdy_w;
            assign txd[gi]      = txd_w;
            assign busy[gi]     = busy_w;
            assign fc[gi]       = 4'(fc_w);
        end
    endgenerate

    function automatic int depth_of(input int i);
        return (i == 2) ? 2 : (i == 3) ? 8 : 4;
    endfunction

    // Receiver model: hunt 0,0,1 then shift in 8 bits LSB first.
    logic [1:0] hist   [N_DUT];
    logic       coll   [N_DUT];
    int         bitn   [N_DUT];
    logic [7:0] sh     [N_DUT];
    logic [7:0] rx_log [N_DUT][128];
    int         rx_time[N_DUT][128];
    int         rx_cnt [N_DUT] = '{default: 0};

    always @(negedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            if (rst) begin
                hist[i] <= 2'b11;
                coll[i] <= 1'b0;
                bitn[i] <= 0;
            end else if (!coll[i]) begin
                if (hist[i] == 2'b00 && txd[i] == 1'b1) begin
                    coll[i] <= 1'b1;
                    bitn[i] <= 0;
                end else begin
                    hist[i] <= {hist[i][0], txd[i]};
                end
            end else begin
                sh[i]   <= {txd[i], sh[i][7:1]};
                bitn[i] <= bitn[i] + 1;
                if (bitn[i] == 7) begin
                    if (rx_cnt[i] < 128) begin
                        rx_log[i][rx_cnt[i]]  <= {txd[i], sh[i][7:1]};
                        rx_time[i][rx_cnt[i]] <= cyc;
                    end
                    rx_cnt[i] <= rx_cnt[i] + 1;
                    coll[i]   <= 1'b0;
                    hist[i]   <= 2'b11;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < N_DUT; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            n_cmp++;
            if (txd[i] !== 1'b1) begin
                n_bad++; $display("FAIL reset_txd[%0d]: got %b want 1", i, txd[i]);
            end
            n_cmp++;
            if (busy[i] !== 1'b0) begin
                n_bad++; $display("FAIL reset_busy[%0d]: got %b want 0", i, busy[i]);
            end
            n_cmp++;
            if (in_ready[i] !== 1'b1) begin
                n_bad++; $display("FAIL reset_in_ready[%0d]: got %b want 1", i, in_ready[i]);
            end
            n_cmp++;
            if (fc[i] !== 4'd0) begin
                n_bad++; $display("FAIL reset_fifo_count[%0d]: got %0d want 0", i, fc[i]);
            end
        end
        rst = 1'b0;
        $display("reset: done");
    endtask

    task automatic test_single();
        logic exp_bits [11];
        int   base;
        exp_bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        base = rx_cnt[0];
        @(negedge clk);
        in_data[0]  = 8'hA5;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        n_cmp++;
        if (fc[0] !== 4'd1) begin
            n_bad++; $display("FAIL single_count_after_push: got %0d want 1", fc[0]);
        end
        n_cmp++;
        if (txd[0] !== 1'b1) begin
            n_bad++; $display("FAIL single_txd_before_pop: got %b want 1", txd[0]);
        end
        for (int b = 0; b < 11; b++) begin
            @(negedge clk);
            n_cmp++;
            if (txd[0] !== exp_bits[b]) begin
                n_bad++; $display("FAIL single_txd_bit%0d: got %b want %b", b, txd[0], exp_bits[b]);
            end
            if (b == 0) begin
                n_cmp++;
                if (busy[0] !== 1'b1) begin
                    n_bad++; $display("FAIL single_busy: got %b want 1", busy[0]);
                end
            end
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            n_cmp++;
            if (txd[0] !== 1'b1) begin
                n_bad++; $display("FAIL single_txd_idle%0d: got %b want 1", b, txd[0]);
            end
        end
        n_cmp++;
        if (busy[0] !== 1'b0) begin
            n_bad++; $display("FAIL single_busy_end: got %b want 0", busy[0]);
        end
        n_cmp++;
        if (rx_cnt[0] !== base + 1 || rx_log[0][base] !== 8'hA5) begin
            n_bad++; $display("FAIL single_rx: got %0d frames data %h want 1 frame data a5",
                              rx_cnt[0] - base, rx_log[0][base]);
        end
        $display("single: sent a5");
    endtask

    task automatic test_fill();
        int acc_cyc [8];
        int exp_diff [8];
        int nb = 0;
        int guard = 0;
        int base;
        logic r;
        logic full_checked = 1'b0;
        exp_diff = '{0, 1, 1, 1, 1, 10, 12, 12};
        base = rx_cnt[0];
        while (nb < 8 && guard < 300) begin
            @(negedge clk);
            if (nb == 5 && !full_checked) begin
                full_checked = 1'b1;
                n_cmp++;
                if (fc[0] !== 4'd4 || in_ready[0] !== 1'b0) begin
                    n_bad++; $display("FAIL fill_full: got count %0d ready %b want 4 0", fc[0], in_ready[0]);
                end
            end
            in_valid[0] = 1'b1;
            in_data[0]  = 8'(nb + 1);
            r = in_ready[0];
            if (r) acc_cyc[nb] = cyc;
            @(posedge clk);
            if (r) nb++;
            guard++;
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        n_cmp++;
        if (nb != 8) begin
            n_bad++; $display("FAIL fill_accept_timeout: got %0d accepted want 8", nb);
        end else begin
            for (int j = 1; j < 8; j++) begin
                n_cmp++;
                if (acc_cyc[j] - acc_cyc[j-1] != exp_diff[j]) begin
                    n_bad++; $display("FAIL fill_accept_spacing%0d: got %0d want %0d",
                                      j, acc_cyc[j] - acc_cyc[j-1], exp_diff[j]);
                end
            end
        end
        guard = 0;
        while (rx_cnt[0] < base + 8 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (rx_cnt[0] < base + 8) begin
            n_bad++; $display("FAIL fill_rx_timeout: got %0d frames want 8", rx_cnt[0] - base);
        end else begin
            for (int j = 0; j < 8; j++) begin
                n_cmp++;
                if (rx_log[0][base+j] !== 8'(j + 1)) begin
                    n_bad++; $display("FAIL fill_rx_data%0d: got %h want %h", j, rx_log[0][base+j], 8'(j + 1));
                end
                if (j > 0) begin
                    n_cmp++;
                    if (rx_time[0][base+j] - rx_time[0][base+j-1] != 12) begin
                        n_bad++; $display("FAIL fill_rx_period%0d: got %0d want 12", j,
                                          rx_time[0][base+j] - rx_time[0][base+j-1]);
                    end
                end
            end
        end
        $display("fill: 8 bytes through depth-4 fifo");
    endtask

    task automatic test_back_to_back_gap0();
        logic exp_bits [24];
        int   base;
        exp_bits = '{1'b0, 1'b0, 1'b1,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        base = rx_cnt[1];
        @(negedge clk);
        in_data[1]  = 8'h00;
        in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data[1] = 8'hFF;
        @(posedge clk);
        for (int b = 0; b < 24; b++) begin
            @(negedge clk);
            in_valid[1] = 1'b0;
            n_cmp++;
            if (txd[1] !== exp_bits[b]) begin
                n_bad++; $display("FAIL gap0_txd_bit%0d: got %b want %b", b, txd[1], exp_bits[b]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (rx_cnt[1] !== base + 2 || rx_log[1][base] !== 8'h00 || rx_log[1][base+1] !== 8'hFF) begin
            n_bad++; $display("FAIL gap0_rx: got %0d frames %h %h want 2 frames 00 ff",
                              rx_cnt[1] - base, rx_log[1][base], rx_log[1][base+1]);
        end
        $display("gap0: sent 00 ff");
    endtask

    task automatic test_reset_mid_frame();
        int base;
        base = rx_cnt[0];
        @(negedge clk);
        in_data[0]  = 8'h11;
        in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data[0] = 8'h22;
        @(posedge clk);
        @(negedge clk);
        in_data[0] = 8'h33;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        n_cmp++;
        if (fc[0] !== 4'd2) begin
            n_bad++; $display("FAIL midrst_count_before: got %0d want 2", fc[0]);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b1 || txd[0] !== 1'b0) begin
            n_bad++; $display("FAIL midrst_in_bit3: got busy %b txd %b want 1 0", busy[0], txd[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (txd[0] !== 1'b1) begin
            n_bad++; $display("FAIL midrst_txd: got %b want 1", txd[0]);
        end
        n_cmp++;
        if (fc[0] !== 4'd0) begin
            n_bad++; $display("FAIL midrst_count: got %0d want 0", fc[0]);
        end
        n_cmp++;
        if (busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_bad++; $display("FAIL midrst_busy_ready: got %b %b want 0 1", busy[0], in_ready[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0) begin
                n_bad++; $display("FAIL midrst_quiet%0d: got txd %b busy %b want 1 0", c, txd[0], busy[0]);
            end
        end
        n_cmp++;
        if (rx_cnt[0] !== base) begin
            n_bad++; $display("FAIL midrst_rx: got %0d frames want 0", rx_cnt[0] - base);
        end
        $display("midrst: frame abandoned, queue flushed");
    endtask

    task automatic test_random(input int i);
        logic [7:0] exp_q [$];
        logic [7:0] d = 8'h00;
        logic v = 1'b0;
        logic acc;
        int sent = 0;
        int guard = 0;
        int base;
        int over = 0;
        base = rx_cnt[i];
        while (sent < 30 && guard < 3000) begin
            @(negedge clk);
            if (!v && $urandom_range(0, 2) != 0) begin
                v = 1'b1;
                d = 8'($urandom);
            end
            in_valid[i] = v;
            in_data[i]  = d;
            acc = v && in_ready[i];
            if (fc[i] > 4'(depth_of(i))) over++;
            @(posedge clk);
            if (acc) begin
                exp_q.push_back(d);
                sent++;
                v = 1'b0;
            end
            guard++;
        end
        @(negedge clk);
        in_valid[i] = 1'b0;
        guard = 0;
        while (rx_cnt[i] < base + exp_q.size() && guard < 3000) begin
            @(negedge clk);
            if (fc[i] > 4'(depth_of(i))) over++;
            guard++;
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (over != 0) begin
            n_bad++; $display("FAIL rand%0d_count_bound: got %0d cycles above depth want 0", i, over);
        end
        n_cmp++;
        if (sent != 30 || rx_cnt[i] != base + exp_q.size()) begin
            n_bad++; $display("FAIL rand%0d_frames: got sent %0d rx %0d want 30 30", i, sent, rx_cnt[i] - base);
        end else begin
            for (int j = 0; j < exp_q.size(); j++) begin
                n_cmp++;
                if (rx_log[i][base+j] !== exp_q[j]) begin
                    n_bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", i, j, rx_log[i][base+j], exp_q[j]);
                end
            end
        end
        n_cmp++;
        if (fc[i] !== 4'd0 || busy[i] !== 1'b0) begin
            n_bad++; $display("FAIL rand%0d_drained: got count %0d busy %b want 0 0", i, fc[i], busy[i]);
        end
        $display("random[%0d]: depth %0d, %0d bytes scored", i, depth_of(i), exp_q.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_back_to_back_gap0();
        test_reset_mid_frame();
        for (int i = 0; i < N_DUT; i++) begin
            test_random(i);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
